// File: rtl/brlshft_pipe.sv
// brlshft_pipe: pipelined barrel shifter/rotator, one stage per amount bit,
// with valid/ready flow control and a pass-through tag.
module brlshft_pipe #(
    parameter int WIDTH = 8,
    parameter int TAG_W = 4,
    parameter int SW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SW-1:0]    in_amt,
    input  logic             in_l_r,
    input  logic [1:0]       in_mode,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [TAG_W-1:0] out_tag
);
    logic             w_stall;
    logic [WIDTH-1:0] w_src_data  [SW];
    logic [WIDTH-1:0] w_nxt_data  [SW];
    logic [SW-1:0]    w_src_amt   [SW];
    logic             w_src_l_r   [SW];
    logic [1:0]       w_src_mode  [SW];
    logic             w_src_sign  [SW];
    logic [TAG_W-1:0] w_src_tag   [SW];
    logic             w_src_valid [SW];
    logic [WIDTH-1:0] r_data  [SW];
    logic [TAG_W-1:0] r_tag   [SW];
    logic             r_valid [SW];
    logic [SW-1:0]    r_amt   [SW-1];
    logic             r_l_r   [SW-1];
    logic [1:0]       r_mode  [SW-1];
    logic             r_sign  [SW-1];

    function automatic logic [WIDTH-1:0] shift_step(input logic [WIDTH-1:0] d, input int sh,
                                                    input logic l_r, input logic [1:0] mode,
                                                    input logic sign);
        logic [WIDTH-1:0] fill;
        fill = (mode == 2'b10 && !l_r && sign) ? ~({WIDTH{1'b1}} >> sh) : '0;
        return mode == 2'b01 ? (l_r ? (d << sh) | (d >> (WIDTH - sh)) : (d >> sh) | (d << (WIDTH - sh)))
                             : (l_r ? d << sh : (d >> sh) | fill);
    endfunction

    assign w_stall   = out_valid && !out_ready;
    assign in_ready  = !w_stall;
    assign out_valid = r_valid[SW-1];
    assign out_data  = r_data[SW-1];
    assign out_tag   = r_tag[SW-1];

    // Each stage consumes bit 0 of its amount and hands the remaining bits on, pre-shifted.
    always_comb begin
        w_src_data[0]  = in_data;
        w_src_amt[0]   = in_amt;
        w_src_l_r[0]   = in_l_r;
        w_src_mode[0]  = in_mode;
        w_src_sign[0]  = in_data[WIDTH-1];
        w_src_tag[0]   = in_tag;
        w_src_valid[0] = in_valid;
        for (int k = 1; k < SW; k++) begin
            w_src_data[k]  = r_data[k-1];
            w_src_amt[k]   = r_amt[k-1];
            w_src_l_r[k]   = r_l_r[k-1];
            w_src_mode[k]  = r_mode[k-1];
            w_src_sign[k]  = r_sign[k-1];
            w_src_tag[k]   = r_tag[k-1];
            w_src_valid[k] = r_valid[k-1];
        end
        for (int k = 0; k < SW; k++)
            w_nxt_data[k] = w_src_amt[k][0] ? shift_step(w_src_data[k], 1 << k, w_src_l_r[k],
                                                         w_src_mode[k], w_src_sign[k])
                                            : w_src_data[k];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < SW; k++) begin
                r_data[k]  <= '0;
                r_tag[k]   <= '0;
                r_valid[k] <= 1'b0;
            end
            for (int k = 0; k < SW - 1; k++) begin
                r_amt[k]  <= '0;
                r_l_r[k]  <= 1'b0;
                r_mode[k] <= 2'b00;
                r_sign[k] <= 1'b0;
            end
        end else if (!w_stall) begin
            for (int k = 0; k < SW; k++) begin
                r_data[k]  <= w_nxt_data[k];
                r_tag[k]   <= w_src_tag[k];
                r_valid[k] <= w_src_valid[k];
            end
            for (int k = 0; k < SW - 1; k++) begin
                r_amt[k]  <= w_src_amt[k] >> 1;
                r_l_r[k]  <= w_src_l_r[k];
                r_mode[k] <= w_src_mode[k];
                r_sign[k] <= w_src_sign[k];
            end
        end
    end
endmodule

// File: tb/tb_brlshft_pipe.sv
// tb_brlshft_pipe: bit-level reference model plus scoreboard for 8- and 4-bit
// instances, with directed literal cases, backpressure, reset and random traffic.
module tb_brlshft_pipe;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid8 = 0, in_ready8, in_l_r8 = 0, out_valid8, out_ready8 = 1;
    logic [7:0] in_data8 = 0, out_data8;
    logic [2:0] in_amt8 = 0;
    logic [1:0] in_mode8 = 0;
    logic [3:0] in_tag8 = 0, out_tag8;
    logic       in_valid4 = 0, in_ready4, in_l_r4 = 0, out_valid4, out_ready4 = 1;
    logic [3:0] in_data4 = 0, out_data4;
    logic [1:0] in_amt4 = 0;
    logic [1:0] in_mode4 = 0;
    logic [3:0] in_tag4 = 0, out_tag4;

    int n_vec = 0, n_err = 0, cyc = 0, out8_cnt = 0, out4_cnt = 0;

    brlshft_pipe #(.WIDTH(8), .TAG_W(4)) u8 (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8), .in_data(in_data8),
        .in_amt(in_amt8), .in_l_r(in_l_r8), .in_mode(in_mode8), .in_tag(in_tag8),
        .out_valid(out_valid8), .out_ready(out_ready8), .out_data(out_data8), .out_tag(out_tag8));

    brlshft_pipe #(.WIDTH(4), .TAG_W(4)) u4 (
        .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4), .in_data(in_data4),
        .in_amt(in_amt4), .in_l_r(in_l_r4), .in_mode(in_mode4), .in_tag(in_tag4),
        .out_valid(out_valid4), .out_ready(out_ready4), .out_data(out_data4), .out_tag(out_tag4));

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        #1_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    // Each result bit is looked up from its source bit position.
    function automatic logic [63:0] ref_shift(input logic [63:0] d, input int a, input bit l,
                                              input logic [1:0] m, input int w);
        logic [63:0] r = '0;
        for (int i = 0; i < w; i++) begin
            if (m == 2'b01) r[i] = d[l ? (i - a + w) % w : (i + a) % w];
            else if (l)     r[i] = (i - a >= 0) ? d[i - a] : 1'b0;
            else            r[i] = (i + a < w) ? d[i + a] : (m == 2'b10 ? d[w - 1] : 1'b0);
        end
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic fail(input string nm);
        n_vec++;
        n_err++;
        $display("FAIL %s", nm);
    endtask

    logic [11:0] q8[$];
    logic [7:0]  q4[$];
    bit          rst_prev = 0, stall8_prev = 0;
    logic [7:0]  prev_d8;
    logic [3:0]  prev_t8;

    always @(negedge clk) begin
        logic [63:0] m64;
        if (rst_prev) begin
            chk("rst_state8", {out_valid8, out_data8, out_tag8, in_ready8}, {1'b0, 8'h00, 4'h0, 1'b1});
            chk("rst_state4", {out_valid4, out_data4, out_tag4, in_ready4}, {1'b0, 4'h0, 4'h0, 1'b1});
        end
        chk("in_ready8", in_ready8, !(out_valid8 && !out_ready8));
        chk("in_ready4", in_ready4, !(out_valid4 && !out_ready4));
        if (stall8_prev && !rst_prev)
            chk("stall_hold8", {out_valid8, out_data8, out_tag8}, {1'b1, prev_d8, prev_t8});
        if (rst) begin
            q8.delete();
            q4.delete();
        end else begin
            if (out_valid8 && out_ready8) begin
                if (q8.size() == 0) fail("unexpected_out8");
                else begin
                    chk("result8", {out_tag8, out_data8}, q8.pop_front());
                    out8_cnt++;
                end
            end
            if (in_valid8 && in_ready8) begin
                m64 = ref_shift(64'(in_data8), int'(in_amt8), in_l_r8, in_mode8, 8);
                q8.push_back({in_tag8, m64[7:0]});
            end
            if (out_valid4 && out_ready4) begin
                if (q4.size() == 0) fail("unexpected_out4");
                else begin
                    chk("result4", {out_tag4, out_data4}, q4.pop_front());
                    out4_cnt++;
                end
            end
            if (in_valid4 && in_ready4) begin
                m64 = ref_shift(64'(in_data4), int'(in_amt4), in_l_r4, in_mode4, 4);
                q4.push_back({in_tag4, m64[3:0]});
            end
        end
        stall8_prev = out_valid8 && !out_ready8 && !rst;
        prev_d8 = out_data8;
        prev_t8 = out_tag8;
        rst_prev = rst;
    end

    task automatic send8(input logic [7:0] d, input logic [2:0] a, input logic l,
                         input logic [1:0] m, input logic [3:0] t);
        int  n = 0;
        bit  acc;
        in_valid8 = 1; in_data8 = d; in_amt8 = a; in_l_r8 = l; in_mode8 = m; in_tag8 = t;
        do begin
            @(negedge clk);
            acc = in_ready8;
            @(posedge clk);
            #1;
            n++;
        end while (!acc && n < 50);
        if (!acc) fail("send8_timeout");
        in_valid8 = 0;
    endtask

    task automatic send8_rand();
        send8(8'($urandom), 3'($urandom), 1'($urandom), 2'($urandom), 4'($urandom));
    endtask

    task automatic lit8(input logic [7:0] d, input logic [2:0] a, input logic l,
                        input logic [1:0] m, input logic [3:0] t, input logic [7:0] exp, input string nm);
        int lat = 0;
        send8(d, a, l, m, t);
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid8 && lat < 10);
        chk({nm, "_lat"}, lat, 3);
        chk({nm, "_data"}, out_data8, exp);
        chk({nm, "_tag"}, out_tag8, t);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int c0, o0;
        repeat (3) @(posedge clk);
        #1 rst = 0;

        lit8(8'b1101_0010, 3'd3, 1'b1, 2'b01, 4'hA, 8'b1001_0110, "rotl3");
        lit8(8'b1101_0010, 3'd2, 1'b0, 2'b00, 4'h1, 8'b0011_0100, "lsr2");
        lit8(8'b1101_0010, 3'd3, 1'b0, 2'b10, 4'h2, 8'b1111_1010, "asr3");
        lit8(8'b1101_0010, 3'd1, 1'b1, 2'b00, 4'h3, 8'b1010_0100, "lsl1");
        lit8(8'b1101_0010, 3'd0, 1'b0, 2'b10, 4'h4, 8'b1101_0010, "amt0_asr");
        lit8(8'b1101_0010, 3'd0, 1'b1, 2'b01, 4'h5, 8'b1101_0010, "amt0_rotl");
        lit8(8'b1000_0001, 3'd7, 1'b0, 2'b10, 4'h6, 8'b1111_1111, "asr7");
        lit8(8'b1000_0001, 3'd7, 1'b1, 2'b11, 4'h7, 8'b1000_0000, "mode3_lsl7");
        lit8(8'b1000_0001, 3'd7, 1'b0, 2'b01, 4'h8, 8'b0000_0011, "rotr7");

        // six words back to back with a four-cycle consumer stall in the middle
        o0 = out8_cnt;
        fork
            repeat (6) send8_rand();
            begin
                repeat (2) @(posedge clk);
                #1 out_ready8 = 0;
                @(negedge clk);
                @(negedge clk);
                chk("bp_in_ready", in_ready8, 1'b0);
                repeat (3) @(posedge clk);
                #1 out_ready8 = 1;
            end
        join
        repeat (10) @(posedge clk);
        #1 chk("bp_count", out8_cnt - o0, 6);

        // reset with three words in flight
        send8_rand(); send8_rand(); send8_rand();
        rst = 1;
        @(posedge clk);
        #1 rst = 0;
        repeat (6) begin
            @(negedge clk);
            chk("no_stale", out_valid8, 1'b0);
        end
        @(posedge clk);
        #1;
        lit8(8'b0110_1001, 3'd4, 1'b1, 2'b01, 4'hC, 8'b1001_0110, "post_rst_rotl4");

        // full-rate streaming: one accept per cycle
        c0 = cyc;
        o0 = out8_cnt;
        repeat (20) send8_rand();
        chk("stream_cycles", cyc - c0, 20);
        repeat (6) @(posedge clk);
        #1 chk("stream_count", out8_cnt - o0, 20);

        // random valid/ready traffic
        fork
            repeat (200) begin
                if ($urandom_range(3) != 0) send8_rand();
                else begin
                    @(posedge clk);
                    #1;
                end
            end
            repeat (300) begin
                out_ready8 = ($urandom_range(2) != 0);
                @(posedge clk);
                #1;
            end
        join
        out_ready8 = 1;
        repeat (10) @(posedge clk);
        #1 chk("rand_drain8", q8.size(), 0);

        // exhaustive 4-bit sweep
        in_valid4 = 1; in_data4 = 4'b1101; in_amt4 = 2'd1; in_l_r4 = 1; in_mode4 = 2'b01; in_tag4 = 4'h9;
        @(posedge clk);
        #1 in_valid4 = 0;
        repeat (2) @(negedge clk);
        chk("w4_rotl1", {out_valid4, out_data4, out_tag4}, {1'b1, 4'b1011, 4'h9});
        @(posedge clk);
        #1;
        o0 = out4_cnt;
        for (int d = 0; d < 16; d++)
            for (int a = 0; a < 4; a++)
                for (int l = 0; l < 2; l++)
                    for (int m = 0; m < 3; m++) begin
                        in_valid4 = 1; in_data4 = 4'(d); in_amt4 = 2'(a); in_l_r4 = 1'(l);
                        in_mode4 = 2'(m); in_tag4 = 4'($urandom);
                        @(posedge clk);
                        #1;
                    end
        in_valid4 = 0;
        repeat (5) @(posedge clk);
        #1 chk("w4_count", out4_cnt - o0, 384);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/brlshft_pipe.md
Name: brlshft_pipe

Overview:
- Parametrised, pipelined successor to the 4-bit combinational barrel shifter.
- Shifts or rotates a WIDTH-bit word by 0..WIDTH-1 positions, left or right, in logical, rotate or arithmetic mode.
- Uses log2(WIDTH) registered stages with valid/ready flow control on both sides.
- Sits between a producer and consumer stream in datapath blocks and carries an opaque tag alongside each word.

Parameters:
- WIDTH, 8, data width; power of two, 4..64.
- TAG_W, 4, width of the pass-through sideband tag; minimum 1.
- SW, $clog2(WIDTH), shift-amount width; derived, not to be overridden.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input word present.
- in_ready  out  1  block can accept the input this cycle.
- in_data  in  WIDTH  operand.
- in_amt  in  SW  shift amount.
- in_l_r  in  1  1 = left, 0 = right.
- in_mode  in  2  00 = logical, 01 = rotate, 10 = arithmetic, 11 = reserved (treated as logical).
- in_tag  in  TAG_W  sideband tag, delivered unchanged with the result.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts the result.
- out_data  out  WIDTH  result.
- out_tag  out  TAG_W  tag of the result.

Behaviour:
- Pipeline structure:
  - SW stages. Stage k applies a shift of 2^k when amt bit k = 1, otherwise passes the word through.
  - Each stage registers data, remaining control (amt, l_r, mode), tag and a valid bit.
  - Stage 0 consumes the accepted input. The stage SW-1 register drives out_*.
- Handshake and stalling:
  - Transfer in: in_valid && in_ready at a rising edge.
  - Transfer out: out_valid && out_ready at a rising edge.
  - stall = out_valid && !out_ready. in_ready = !stall (combinational).
  - On stall, every stage register holds, including data, tag and valid.
  - No bubble collapsing. Empty stages still advance only when not stalled.
- Latency and throughput:
  - Input accepted at edge N appears on out_* after edge N+SW-1 (SW cycles in flight) when there are no stalls.
  - Throughput is one word per cycle.
  - While stalled, out_data and out_tag are stable and out_valid stays 1 until the transfer.
- Shift semantics (WIDTH bits, amount a):
  - Logical left: vacated LSBs filled with 0.
  - Logical right: vacated MSBs filled with 0.
  - Rotate: bits wrap around; left and right are both supported.
  - Arithmetic right: vacated MSBs filled with the original in_data MSB. The sign bit is captured at stage 0 and carried through the stages.
  - Arithmetic left: identical to logical left.
  - Mode 11: identical to logical.
  - a = 0: output equals input in every mode.
- Reset:
  - While rst = 1, all stage valid bits clear; out_valid = 0, out_data = 0, out_tag = 0.
  - in_ready = 1 during and after reset, since out_valid = 0.
  - Reset mid-operation discards all in-flight words; none are delivered later.
  - rst has priority over the handshake in the same cycle.
- Simultaneous events:
  - Input accept and output transfer in the same cycle are legal; the pipeline advances.
  - in_valid while in_ready = 0 is ignored. The producer must hold its data, and the block must not capture it.
  - out_ready = 1 while out_valid = 0 has no effect.
- Boundary:
  - Maximum amount WIDTH-1 is legal in all modes.
  - in_amt is exactly SW bits, so out-of-range amounts cannot occur.

Test Plan:
- Rotate left, WIDTH=8: in_data=8'b1101_0010, amt=3, l_r=1, mode=01, tag=4'hA, out_ready=1 -> out_data=8'b1001_0110, out_tag=4'hA, out_valid high exactly 3 cycles after accept.
- Shift modes, WIDTH=8, in_data=8'b1101_0010:
  - right logical, amt=2 -> 8'b0011_0100.
  - right arithmetic, amt=3 -> 8'b1111_1010.
  - left logical, amt=1 -> 8'b1010_0100.
  - any mode, amt=0 -> 8'b1101_0010.
- Back-to-back with backpressure: stream 6 words on consecutive cycles; drop out_ready for 4 cycles mid-stream -> in_ready=0 during the stall, out_data/out_tag stable, all 6 results delivered in order with no loss or duplication.
- Exhaustive WIDTH=4 instance: all 16 in_data x 4 amounts x both directions x modes 00/01/10 -> matches the reference model; spot check in_data=4'b1101, rotate left 1 -> 4'b1011.
- Reset mid-flight: accept 3 words, assert rst for 1 cycle while out_ready=1 -> out_valid=0, out_data=0 the following cycle, no stale word ever appears, and a new word accepted after reset emerges with correct latency.
- Simultaneous in/out: with the pipeline full and out_ready=1, keep in_valid=1 every cycle -> one accept and one delivery per cycle, in_ready held 1.
